// File: rtl/usb_tx_crc16_append.sv
// USB SIE transmit DATA-packet stage: forwards payload bytes to the serializer, feeds each
// byte to an external updateCRC16 engine and appends the CRC16 trailer, low byte first.
module usb_tx_crc16_append #(
   parameter bit          INVERT_CRC = 1'b1,
   parameter int unsigned GUARD_CYC  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  txByte,
   input  logic        txValid,
   input  logic        txLast,
   input  logic        txEmpty,
   input  logic        txAbort,
   output logic        txReady,
   output logic [7:0]  outByte,
   output logic        outValid,
   input  logic        outReady,
   output logic        crcRst,
   output logic        crcEn,
   output logic [7:0]  crcData,
   input  logic        crcReady,
   input  logic [15:0] crcResult,
   output logic        busy
);

   localparam int unsigned GW = (GUARD_CYC < 2) ? 1 : $clog2(GUARD_CYC + 1);

   typedef enum logic [2:0] {
      IDLE,
      FEED,
      WAIT_CRC,
      SEND_HI,
      CLEAR
   } state_t;

   state_t        state;
   logic [GW-1:0] guard;
   logic          out_free;
   logic          crc_ok;
   logic          accept;
   logic [15:0]   trailer;

   // A stale crcReady right after a crcEn pulse is masked by the guard counter;
   // no byte is taken while the engine is being cleared.
   assign out_free = ~outValid | outReady;
   assign crc_ok   = crcReady & (guard == '0);
   assign txReady  = ((state == IDLE) | (state == FEED)) & out_free & crc_ok & ~crcRst & ~txAbort;
   assign accept   = txValid & txReady;
   assign trailer  = INVERT_CRC ? ~crcResult : crcResult;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         guard    <= '0;
         outByte  <= 8'h00;
         outValid <= 1'b0;
         crcEn    <= 1'b0;
         crcData  <= 8'h00;
         crcRst   <= 1'b1;
         busy     <= 1'b0;
      end else begin
         crcEn  <= 1'b0;
         crcRst <= 1'b0;
         if (outValid & outReady) outValid <= 1'b0;

         if (accept)              guard <= GW'(GUARD_CYC);
         else if (guard != '0)    guard <= guard - GW'(1);

         if (txAbort) begin
            outValid <= 1'b0;
            crcRst   <= 1'b1;
            busy     <= 1'b0;
            guard    <= '0;
            state    <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     outByte  <= txByte;
                     outValid <= 1'b1;
                     crcData  <= txByte;
                     crcEn    <= 1'b1;
                     busy     <= 1'b1;
                     state    <= txLast ? WAIT_CRC : FEED;
                  end else if (txEmpty & ~txValid) begin
                     busy  <= 1'b1;
                     state <= WAIT_CRC;
                  end
               end
               FEED: begin
                  if (accept) begin
                     outByte  <= txByte;
                     outValid <= 1'b1;
                     crcData  <= txByte;
                     crcEn    <= 1'b1;
                     if (txLast) state <= WAIT_CRC;
                  end
               end
               WAIT_CRC: begin
                  if (crc_ok & out_free) begin
                     outByte  <= trailer[7:0];
                     outValid <= 1'b1;
                     state    <= SEND_HI;
                  end
               end
               SEND_HI: begin
                  // The engine is cleared as the high byte is captured, so crcRst is high
                  // for the first cycle of CLEAR only.
                  if (out_free) begin
                     outByte  <= trailer[15:8];
                     outValid <= 1'b1;
                     crcRst   <= 1'b1;
                     state    <= CLEAR;
                  end
               end
               CLEAR: begin
                  if (out_free) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
